// File: rtl/writeback.sv
// writeback: retires the memory-stage bundle into the integer register file.
// Also owns the pending-write scoreboard, branch redirect and end-of-program flush.
module writeback #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 64,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     mem_result_q,
  input  logic                mem_result_valid_q,
  input  logic                mem_result_is_branch_addr_q,
  input  logic                mem_write_to_rd_q,
  input  logic [AW-1:0]       mem_rd_q,
  input  logic                mem_should_end_program_q,
  input  logic [AW-1:0]       rs1_addr,
  input  logic [AW-1:0]       rs2_addr,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  input  logic                issue_valid,
  input  logic                issue_writes_rd,
  input  logic [AW-1:0]       issue_rd,
  output logic [NUM_REGS-1:0] rd_busy,
  output logic                branch_invalidate,
  output logic [XLEN-1:0]     branch_target,
  output logic                cache_flush_req,
  input  logic                cache_flush_done,
  output logic                halted,
  output logic [63:0]         instret
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    HALTED
  } state_t;

  state_t state;

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_next;
  logic accepted;
  logic wr_en;
  logic issue_set;

  assign accepted  = mem_result_valid_q && (state == RUN);
  assign wr_en     = accepted && mem_write_to_rd_q
                   && !mem_result_is_branch_addr_q
                   && (mem_rd_q != '0);
  assign issue_set = issue_valid && issue_writes_rd
                   && (issue_rd != '0);

  assign branch_invalidate = accepted && mem_result_is_branch_addr_q;
  assign branch_target     = mem_result_q;

  // Read ports: x0 is hardwired, same-cycle write is bypassed.
  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (wr_en && (rs1_addr == mem_rd_q))
      rs1_data = mem_result_q;
  end

  // Second read port, same rules as the first.
  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (wr_en && (rs2_addr == mem_rd_q))
      rs2_data = mem_result_q;
  end

  // Scoreboard next state: redirect wipes, retire clears, issue set wins.
  always_comb begin
    busy_next = rd_busy;
    if (branch_invalidate)
      busy_next = '0;
    else if (wr_en)
      busy_next[mem_rd_q] = 1'b0;
    if (issue_set)
      busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Register file storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[mem_rd_q] <= mem_result_q;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_busy <= '0;
    else
      rd_busy <= busy_next;
  end

  // Retired-entry counter; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      instret <= '0;
    else if (accepted)
      instret <= instret + 64'd1;
  end

  // End-of-program sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= RUN;
      cache_flush_req <= 1'b0;
      halted          <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accepted && mem_should_end_program_q) begin
            state           <= FLUSH;
            cache_flush_req <= 1'b1;
          end
        end
        FLUSH: begin
          if (cache_flush_done) begin
            state           <= HALTED;
            cache_flush_req <= 1'b0;
            halted          <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state           <= RUN;
          cache_flush_req <= 1'b0;
          halted          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: vector table plus hand-written end/flush/reset sequences.
// Post-edge expectations travel through a scoreboard queue.
module tb_writeback;
  localparam int XLEN = 64;
  localparam int NR   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] mem_result_q;
  logic            mem_result_valid_q;
  logic            mem_result_is_branch_addr_q;
  logic            mem_write_to_rd_q;
  logic [4:0]      mem_rd_q;
  logic            mem_should_end_program_q;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            issue_valid, issue_writes_rd;
  logic [4:0]      issue_rd;
  logic [NR-1:0]   rd_busy;
  logic            branch_invalidate;
  logic [XLEN-1:0] branch_target;
  logic            cache_flush_req, cache_flush_done, halted;
  logic [63:0]     instret;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .rst(rst),
    .mem_result_q(mem_result_q),
    .mem_result_valid_q(mem_result_valid_q),
    .mem_result_is_branch_addr_q(mem_result_is_branch_addr_q),
    .mem_write_to_rd_q(mem_write_to_rd_q),
    .mem_rd_q(mem_rd_q),
    .mem_should_end_program_q(mem_should_end_program_q),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid),
    .issue_writes_rd(issue_writes_rd),
    .issue_rd(issue_rd),
    .rd_busy(rd_busy),
    .branch_invalidate(branch_invalidate),
    .branch_target(branch_target),
    .cache_flush_req(cache_flush_req),
    .cache_flush_done(cache_flush_done),
    .halted(halted),
    .instret(instret)
  );

  typedef struct {
    logic        v, br, wr, en;
    logic [4:0]  rd;
    logic [63:0] val;
    logic [4:0]  a1, a2;
    logic        iv, iw;
    logic [4:0]  ird;
    logic [63:0] e1, e2;
    logic        ebinv;
    logic [63:0] einst;
    logic [31:0] ebusy;
  } vec_t;

  typedef struct {
    logic [63:0] inst;
    logic [31:0] busy;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  localparam logic [63:0] DB   = 64'hDEADBEEF_00000001;
  localparam logic [63:0] ONES = 64'hFFFFFFFF_FFFFFFFF;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, br, wr, en, input logic [4:0] rd,
                       input logic [63:0] val, input logic [4:0] a1, a2,
                       input logic iv, iw, input logic [4:0] ird);
    @(negedge clk);
    mem_result_valid_q          = v;
    mem_result_is_branch_addr_q = br;
    mem_write_to_rd_q           = wr;
    mem_should_end_program_q    = en;
    mem_rd_q                    = rd;
    mem_result_q                = val;
    rs1_addr                    = a1;
    rs2_addr                    = a2;
    issue_valid                 = iv;
    issue_writes_rd             = iw;
    issue_rd                    = ird;
    #1;
  endtask

  task automatic idle(input logic [4:0] a1, a2);
    drive(0, 0, 0, 0, 5'd0, 64'd0, a1, a2, 0, 0, 5'd0);
  endtask

  task automatic row(input logic v, br, wr, en, input logic [4:0] rd,
                     input logic [63:0] val, input logic [4:0] a1, a2,
                     input logic iv, iw, input logic [4:0] ird,
                     input logic [63:0] e1, e2, input logic ebinv,
                     input logic [63:0] einst, input logic [31:0] ebusy);
    vec_t t;
    t = '{v, br, wr, en, rd, val, a1, a2, iv, iw, ird,
          e1, e2, ebinv, einst, ebusy};
    vt.push_back(t);
  endtask

  task automatic post_edge(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " instret"}, instret, e.inst);
      check({tag, " rd_busy"}, {32'd0, rd_busy}, {32'd0, e.busy});
    end
  endtask

  initial begin
    rst = 1'b0;
    cache_flush_done = 1'b0;
    mem_result_valid_q = 0; mem_result_is_branch_addr_q = 0;
    mem_write_to_rd_q = 0; mem_should_end_program_q = 0;
    mem_rd_q = 0; mem_result_q = 0;
    rs1_addr = 5; rs2_addr = 31;
    issue_valid = 0; issue_writes_rd = 0; issue_rd = 0;
    #2;
    check("reset req", {63'd0, cache_flush_req}, 64'd0);
    check("reset halted", {63'd0, halted}, 64'd0);
    check("reset instret", instret, 64'd0);
    check("reset busy", {32'd0, rd_busy}, 64'd0);
    check("reset x5", rs1_data, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // v br wr en rd val a1 a2 iv iw ird | e1 e2 binv inst busy
    row(1,0,1,0, 5, DB,      5, 0, 0,0,0, DB,   0,    0, 1, 32'h0);
    row(0,0,0,0, 0, 0,       5, 5, 0,0,0, DB,   DB,   0, 1, 32'h0);
    row(1,0,1,0, 0, 64'h1234,0, 0, 0,0,0, 0,    0,    0, 2, 32'h0);
    row(0,0,0,0, 0, 0,       7, 5, 1,1,7, 0,    DB,   0, 2, 32'h80);
    row(1,0,1,0, 7, 64'h77,  7, 0, 1,1,7, 64'h77,0,   0, 3, 32'h80);
    row(1,0,1,0, 7, 64'h78,  7, 0, 0,0,0, 64'h78,0,   0, 4, 32'h0);
    row(0,0,0,0, 0, 0,       3, 7, 1,1,3, 0,    64'h78,0,4, 32'h8);
    row(0,0,0,0, 0, 0,       7, 0, 1,1,9, 64'h78,0,   0, 4, 32'h208);
    row(0,0,0,0, 0, 0,       0, 0, 1,1,0, 0,    0,    0, 4, 32'h208);
    row(0,0,0,0, 0, 0,       0, 0, 1,0,4, 0,    0,    0, 4, 32'h208);
    row(1,1,1,0, 3, 64'h80000040, 3, 9, 0,0,0, 0, 0,  1, 5, 32'h0);
    row(0,0,0,0, 0, 0,       3, 9, 0,0,0, 0,    0,    0, 5, 32'h0);
    row(1,0,0,0, 6, 64'h66,  6, 0, 0,0,0, 0,    0,    0, 6, 32'h0);
    row(0,0,0,0, 0, 0,       6, 5, 0,0,0, 0,    DB,   0, 6, 32'h0);
    row(1,0,1,0, 31, ONES,   0, 31,0,0,0, 0,    ONES, 0, 7, 32'h0);
    row(0,0,1,0, 12, 64'h99, 12,0, 0,0,0, 0,    0,    0, 7, 32'h0);
    row(0,0,0,0, 0, 0,       12,31,0,0,0, 0,    ONES, 0, 7, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      vec_t t;
      string tag;
      t = vt[i];
      tag = $sformatf("vec%0d", i);
      drive(t.v, t.br, t.wr, t.en, t.rd, t.val, t.a1, t.a2,
            t.iv, t.iw, t.ird);
      check({tag, " rs1"}, rs1_data, t.e1);
      check({tag, " rs2"}, rs2_data, t.e2);
      check({tag, " binv"}, {63'd0, branch_invalidate}, {63'd0, t.ebinv});
      if (t.ebinv)
        check({tag, " target"}, branch_target, t.val);
      sb.push_back('{t.einst, t.ebusy});
      post_edge(tag);
    end

    // done pulse while running is ignored
    idle(0, 0);
    cache_flush_done = 1'b1;
    @(posedge clk);
    #1;
    check("early done halted", {63'd0, halted}, 64'd0);
    check("early done req", {63'd0, cache_flush_req}, 64'd0);

    // end entry retires and starts the flush
    drive(1, 0, 1, 1, 5'd10, 64'd42, 5'd10, 5'd0, 0, 0, 5'd0);
    cache_flush_done = 1'b0;
    check("end bypass", rs1_data, 64'd42);
    @(posedge clk);
    #1;
    check("end req", {63'd0, cache_flush_req}, 64'd1);
    check("end instret", instret, 64'd8);
    idle(5'd10, 5'd0);
    check("end x10", rs1_data, 64'd42);

    // entries during the flush are discarded
    for (int i = 0; i < 20; i++) begin
      drive(1, i == 3, 1, 0, 5'd11, 64'd100 + 64'(i), 5'd11, 5'd0,
            0, 0, 5'd0);
      check("flush binv", {63'd0, branch_invalidate}, 64'd0);
      check("flush bypass", rs1_data, 64'd0);
      @(posedge clk);
      #1;
      check("flush instret", instret, 64'd8);
      check("flush req", {63'd0, cache_flush_req}, 64'd1);
    end

    idle(5'd11, 5'd0);
    cache_flush_done = 1'b1;
    @(posedge clk);
    #1;
    check("done halted", {63'd0, halted}, 64'd1);
    check("done req", {63'd0, cache_flush_req}, 64'd0);
    idle(5'd11, 5'd0);
    cache_flush_done = 1'b0;
    check("flush x11", rs1_data, 64'd0);

    // second done pulse while halted does nothing
    drive(1, 0, 1, 0, 5'd12, 64'd5, 5'd12, 5'd0, 0, 0, 5'd0);
    cache_flush_done = 1'b1;
    @(posedge clk);
    #1;
    check("halt2 halted", {63'd0, halted}, 64'd1);
    check("halt2 req", {63'd0, cache_flush_req}, 64'd0);
    check("halt2 instret", instret, 64'd8);
    idle(5'd12, 5'd0);
    cache_flush_done = 1'b0;
    check("halt2 x12", rs1_data, 64'd0);

    // full reset, then an end entry that is also a branch
    rst = 1'b0;
    #1;
    check("rst2 halted", {63'd0, halted}, 64'd0);
    check("rst2 x10", {rs1_data}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 1, 1, 5'd2, 64'h80001000, 5'd5, 5'd2, 0, 0, 5'd0);
    check("endbr binv", {63'd0, branch_invalidate}, 64'd1);
    check("endbr target", branch_target, 64'h80001000);
    check("rst2 x5", rs1_data, 64'd0);
    @(posedge clk);
    #1;
    check("endbr req", {63'd0, cache_flush_req}, 64'd1);
    check("endbr instret", instret, 64'd1);
    drive(0, 0, 0, 0, 5'd0, 64'd0, 5'd0, 5'd0, 1, 1, 5'd4);
    @(posedge clk);
    #1;
    check("flush issue busy", {32'd0, rd_busy}, 64'h10);

    // asynchronous reset in the middle of the flush
    #2;
    rst = 1'b0;
    issue_valid = 1'b0;
    issue_writes_rd = 1'b0;
    #1;
    check("mid rst req", {63'd0, cache_flush_req}, 64'd0);
    check("mid rst halted", {63'd0, halted}, 64'd0);
    check("mid rst instret", instret, 64'd0);
    check("mid rst busy", {32'd0, rd_busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    drive(1, 0, 1, 0, 5'd5, 64'h55, 5'd5, 5'd2, 0, 0, 5'd0);
    check("after rst bypass", rs1_data, 64'h55);
    check("after rst x2", rs2_data, 64'd0);
    sb.push_back('{64'd1, 32'h0});
    post_edge("after rst");
    check("after rst req", {63'd0, cache_flush_req}, 64'd0);
    idle(5'd5, 5'd0);
    check("after rst x5", rs1_data, 64'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback.md
# writeback

Final pipeline stage, directly downstream of the memory read/write stage. It consumes that stage's registered result bundle and retires it into a 32 x 64-bit integer register file. It also provides:
- combinational register reads with write-through bypass for decode;
- a per-register pending-write scoreboard used by decode to stall;
- the branch-redirect strobe;
- an end-of-program sequence that flushes the data cache before halting.

## Interface
Parameters
- NUM_REGS, 32, architectural register count; index width is $clog2(NUM_REGS) = 5.
- XLEN, 64, data width.

Ports
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_result_q  in  XLEN  retiring value, or branch target when mem_result_is_branch_addr_q=1.
- mem_result_valid_q  in  1  bundle valid.
- mem_result_is_branch_addr_q  in  1  entry is a taken branch; result is the target.
- mem_write_to_rd_q  in  1  entry writes rd.
- mem_rd_q  in  5  destination register.
- mem_should_end_program_q  in  1  entry ends the program.
- rs1_addr, rs2_addr  in  5 each  decode read addresses.
- rs1_data, rs2_data  out  XLEN each  read data, combinational.
- issue_valid  in  1  decode issued an instruction this cycle.
- issue_writes_rd  in  1  the issued instruction writes rd.
- issue_rd  in  5  the issued instruction's rd.
- rd_busy  out  NUM_REGS  scoreboard; bit i=1 means register i has a pending write.
- branch_invalidate  out  1  combinational redirect strobe to all earlier stages.
- branch_target  out  XLEN  combinational; equals mem_result_q.
- cache_flush_req  out  1  registered; request for the data cache to write back all dirty lines.
- cache_flush_done  in  1  single-cycle pulse from the cache.
- halted  out  1  registered; program finished.
- instret  out  64  registered count of retired entries.

## Operation
Entry qualification
- An entry is accepted when mem_result_valid_q=1 and state=RUN.
- Entries arriving in FLUSH or HALTED are discarded: no write, no count, no strobe.

Register file write
- A write occurs when the entry is accepted, mem_write_to_rd_q=1, mem_result_is_branch_addr_q=0 and mem_rd_q!=0.
- Branch entries never write rd. Link values retire as a separate non-branch entry.

Register file read
- Reads are combinational.
- Address 0 returns 0.
- If the read address equals the address being written this cycle, the read returns mem_result_q (bypass).

Scoreboard
- On issue_valid & issue_writes_rd & issue_rd!=0, set bit issue_rd.
- On a register file write, clear bit mem_rd_q.
- If set and clear target the same register in one cycle, set wins.
- On branch_invalidate, clear all bits, then apply the same-cycle issue set. Decode guarantees issue_valid=0 while branch_invalidate=1; if both occur anyway, the set is still applied.
- Bit 0 is always 0.

Branch
- branch_invalidate = accepted & mem_result_is_branch_addr_q.

instret
- Increments by 1 per accepted entry, including branch and end entries.
- Wraps at 2^64 - 1 to 0.

State machine (RUN, FLUSH, HALTED)
- RUN -> FLUSH when an accepted entry has mem_should_end_program_q=1. That entry still writes rd and counts.
- In FLUSH, cache_flush_req=1. Leave FLUSH on cache_flush_done=1.
- FLUSH -> HALTED on cache_flush_done.
- HALTED is absorbing until reset.
- cache_flush_done outside FLUSH is ignored.

## Timing
Reset values (asynchronous assert, synchronous release)
- state=RUN, all 32 registers=0, rd_busy=0, instret=0, cache_flush_req=0, halted=0.
- A reset mid-FLUSH abandons the flush: cache_flush_req drops asynchronously.

Latency
- Register write is visible in the array at the next edge; the bypass covers the write cycle itself.
- rd_busy clear is visible the cycle after the write cycle; bypass data is already correct in the write cycle.
- branch_invalidate and branch_target: 0 cycles, same cycle as the entry.
- End entry at edge N: state=FLUSH and cache_flush_req=1 from N+1.
- cache_flush_done sampled at edge M: halted=1 and cache_flush_req=0 from M+1.
- cache_flush_req holds steady until done; it is a level handshake.

Other cycle-level rules
- An end entry that is also a branch: the strobe still fires and the state still moves to FLUSH.
- This stage never stalls upstream: one entry per cycle is always accepted in RUN.

## Test plan
- Write/bypass: entry rd=5, value 0xDEADBEEF_00000001, with rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF_00000001 that cycle and every following cycle; instret=1.
- x0: entry rd=0, value 0x1234 -> rs2_addr=0 reads 0; rd_busy[0]=0; instret increments.
- Scoreboard: issue rd=7, then retire rd=7 while issuing rd=7 in the same cycle -> rd_busy[7] remains 1. A later retire with no issue -> rd_busy[7]=0 next cycle.
- Branch: busy bits {3,9} set; branch entry with target 0x8000_0040, write_to_rd=1, rd=3 -> branch_invalidate=1 with branch_target=0x8000_0040 the same cycle; x3 unchanged; rd_busy=0 next cycle.
- End sequence: end entry rd=10, value 42 -> x10=42; cache_flush_req=1 next cycle. Valid entries during FLUSH -> no writes, instret frozen. cache_flush_done pulse after 20 cycles -> halted=1 and req=0 next cycle; a later done pulse has no effect.
- Reset mid-FLUSH: drive rst=0 asynchronously between edges -> cache_flush_req, halted, instret and rd_busy go to 0 immediately; after release, state=RUN and entries retire normally.
